// File: rtl/ec_pkg.sv
// Shared types and elaboration-time helpers for the EC field-arithmetic layer.
package ec_pkg;

  typedef enum logic [2:0] {
    INV_IDLE,
    INV_SQR_REQ,
    INV_SQR_WAIT,
    INV_MUL_REQ,
    INV_MUL_WAIT,
    INV_NEXT,
    INV_DONE
  } inv_state_t;

  // Position of the highest set bit; 0 for e == 0.
  function automatic int msb_index(input logic [63:0] e);
    int m;
    m = 0;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) m = i;
    end
    return m;
  endfunction

endpackage

// File: rtl/ec_fp_inv_fermat.sv
// Fp inverse a^(P-2) mod P by left-to-right square-and-multiply on an external multiplier.
// Optional zero bypass with error flag: EC_FP_INV_ZERO_CHECK_EN.
//   state    | meaning
//   IDLE     | ready for an operand
//   SQR_REQ  | request r*r
//   SQR_WAIT | wait for square product
//   MUL_REQ  | request r*a
//   MUL_WAIT | wait for multiply product
//   NEXT     | advance to next exponent bit
//   DONE     | result valid, wait for downstream
module ec_fp_inv_fermat
  import ec_pkg::*;
#(
  parameter int P        = 17,
  parameter int DAT_BITS = $clog2(P),
  parameter int CTL_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DAT_BITS-1:0] i_dat,
  input  logic                i_val,
  input  logic [CTL_BITS-1:0] i_ctl,
  output logic                o_rdy,
  output logic [DAT_BITS-1:0] o_dat,
  output logic [CTL_BITS-1:0] o_ctl,
  output logic                o_err,
  output logic                o_val,
  input  logic                i_rdy,
  output logic [DAT_BITS-1:0] o_mul_dat_a,
  output logic [DAT_BITS-1:0] o_mul_dat_b,
  output logic                o_mul_val,
  input  logic                i_mul_rdy,
  input  logic [DAT_BITS-1:0] i_mul_dat,
  input  logic                i_mul_val,
  output logic                o_mul_rdy
);

  localparam logic [DAT_BITS-1:0] E = DAT_BITS'(P - 2);
  localparam int MSB = msb_index(64'(E));
  localparam int IDX_BITS = (DAT_BITS > 1) ? $clog2(DAT_BITS) : 1;
  localparam logic [IDX_BITS-1:0] IDX_START = IDX_BITS'((MSB > 0) ? MSB - 1 : 0);

  inv_state_t state, state_nxt;
  logic [DAT_BITS-1:0] a_q, r_q;
  logic [CTL_BITS-1:0] ctl_q;
  logic [IDX_BITS-1:0] idx_q;
  logic                rdy_idle;
  logic                skip_exp;

`ifdef EC_FP_INV_ZERO_CHECK_EN
  logic err_q;

  assign skip_exp = (MSB == 0) || (i_dat == '0);
  assign o_err    = err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (state == INV_IDLE && i_val) begin
      err_q <= (i_dat == '0);
    end
  end
`else
  assign skip_exp = (MSB == 0);
  assign o_err    = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= INV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q   <= '0;
      r_q   <= '0;
      ctl_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        INV_IDLE: begin
          if (i_val) begin
            a_q   <= i_dat;
            r_q   <= i_dat;
            ctl_q <= i_ctl;
            idx_q <= IDX_START;
          end
        end
        INV_SQR_WAIT, INV_MUL_WAIT: begin
          if (i_mul_val) r_q <= i_mul_dat;
        end
        INV_NEXT: begin
          if (idx_q != '0) idx_q <= idx_q - IDX_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rdy_idle  = 1'b0;
    o_mul_val = 1'b0;
    o_mul_rdy = 1'b0;
    o_val     = 1'b0;
    case (state)
      INV_IDLE: begin
        rdy_idle = 1'b1;
        if (i_val) state_nxt = skip_exp ? INV_DONE : INV_SQR_REQ;
      end
      INV_SQR_REQ: begin
        o_mul_val = 1'b1;
        if (i_mul_rdy) state_nxt = INV_SQR_WAIT;
      end
      INV_SQR_WAIT: begin
        o_mul_rdy = 1'b1;
        if (i_mul_val) state_nxt = E[idx_q] ? INV_MUL_REQ : INV_NEXT;
      end
      INV_MUL_REQ: begin
        o_mul_val = 1'b1;
        if (i_mul_rdy) state_nxt = INV_MUL_WAIT;
      end
      INV_MUL_WAIT: begin
        o_mul_rdy = 1'b1;
        if (i_mul_val) state_nxt = INV_NEXT;
      end
      INV_NEXT: begin
        state_nxt = (idx_q == '0) ? INV_DONE : INV_SQR_REQ;
      end
      INV_DONE: begin
        o_val = 1'b1;
        if (i_rdy) state_nxt = INV_IDLE;
      end
      default: state_nxt = INV_IDLE;
    endcase
  end

  // Ready is suppressed while reset is asserted even though the state already reads IDLE.
  assign o_rdy       = rdy_idle & ~i_rst;
  assign o_dat       = r_q;
  assign o_ctl       = ctl_q;
  assign o_mul_dat_a = r_q;
  assign o_mul_dat_b = (state == INV_MUL_REQ) ? a_q : r_q;

endmodule

// File: tb/tb_ec_fp_inv_fermat.sv
// Directed bench for ec_fp_inv_fermat (P=17) with a behavioural multiplier model.
module tb_ec_fp_inv_fermat;

  localparam int P  = 17;
  localparam int DW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] i_dat = '0;
  logic          i_val = 1'b0;
  logic [CW-1:0] i_ctl = '0;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [CW-1:0] o_ctl;
  logic          o_err;
  logic          o_val;
  logic          i_rdy = 1'b0;
  logic [DW-1:0] o_mul_dat_a, o_mul_dat_b;
  logic          o_mul_val;
  logic          i_mul_rdy;
  logic [DW-1:0] i_mul_dat;
  logic          i_mul_val;
  logic          o_mul_rdy;

  int n_cmp = 0;
  int n_err = 0;

  logic stall_en = 1'b0;
  logic rand_lat = 1'b0;
  int   req_cnt  = 0;
  logic [DW-1:0] log_a [256];
  logic [DW-1:0] log_b [256];

  int inv_tab [17] = '{0, 1, 9, 6, 13, 7, 3, 5, 15, 2, 12, 14, 10, 4, 11, 8, 16};
  int exp_a [6] = '{3, 9, 10, 15, 11, 2};
  int exp_b [6] = '{3, 3, 10, 3, 11, 3};

  always #5 clk = ~clk;

  ec_fp_inv_fermat #(.P(P), .DAT_BITS(DW), .CTL_BITS(CW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dat       (i_dat),
    .i_val       (i_val),
    .i_ctl       (i_ctl),
    .o_rdy       (o_rdy),
    .o_dat       (o_dat),
    .o_ctl       (o_ctl),
    .o_err       (o_err),
    .o_val       (o_val),
    .i_rdy       (i_rdy),
    .o_mul_dat_a (o_mul_dat_a),
    .o_mul_dat_b (o_mul_dat_b),
    .o_mul_val   (o_mul_val),
    .i_mul_rdy   (i_mul_rdy),
    .i_mul_dat   (i_mul_dat),
    .i_mul_val   (i_mul_val),
    .o_mul_rdy   (o_mul_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Multiplier model: one request at a time, product (A*B) mod P after a configurable delay.
  initial begin
    logic          busy, req_xfer, prod_xfer, held_v;
    logic [DW-1:0] pend;
    logic [2*DW-1:0] held_ab;
    int cnt;
    busy = 0; req_xfer = 0; prod_xfer = 0; held_v = 0; pend = '0; held_ab = '0; cnt = 0;
    i_mul_rdy = 1'b0; i_mul_val = 1'b0; i_mul_dat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        i_mul_rdy = 1'b0; i_mul_val = 1'b0; i_mul_dat = '0;
        busy = 0; req_xfer = 0; prod_xfer = 0; held_v = 0;
      end else begin
        if (prod_xfer) begin
          i_mul_val = 1'b0; busy = 0; prod_xfer = 0;
        end
        if (req_xfer) begin
          busy = 1; req_xfer = 0;
          cnt = rand_lat ? int'($urandom_range(1, 10)) : 4;
        end
        if (busy && !i_mul_val) begin
          if (cnt <= 1) begin
            i_mul_val = 1'b1; i_mul_dat = pend;
          end else begin
            cnt--;
          end
        end
        if (i_mul_val) chk("mul_proto", o_mul_rdy, 1);
        prod_xfer = i_mul_val && o_mul_rdy;
        if (held_v && o_mul_val) chk("mul_hold", {o_mul_dat_a, o_mul_dat_b}, held_ab);
        held_v = 0;
        i_mul_rdy = !busy && (!stall_en || ($urandom_range(0, 1) == 1));
        if (o_mul_val && i_mul_rdy) begin
          req_xfer = 1;
          pend = DW'((int'(o_mul_dat_a) * int'(o_mul_dat_b)) % P);
          log_a[req_cnt & 255] = o_mul_dat_a;
          log_b[req_cnt & 255] = o_mul_dat_b;
          req_cnt++;
        end else if (o_mul_val) begin
          held_v = 1; held_ab = {o_mul_dat_a, o_mul_dat_b};
        end
      end
    end
  end

  task automatic run_op(input logic [DW-1:0] a, input logic [CW-1:0] tag, input int hold,
                        output logic [DW-1:0] res, output logic [CW-1:0] ctl, output logic err);
    int cyc;
    logic [DW-1:0] d0;
    res = '0; ctl = '0; err = 1'b0;
    cyc = 0;
    while (!o_rdy && cyc < 50) begin @(negedge clk); cyc++; end
    if (!o_rdy) begin chk("rdy_timeout", 0, 1); return; end
    i_dat = a; i_ctl = tag; i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0; i_dat = '0; i_ctl = '0;
    chk("rdy_busy", o_rdy, 0);
    cyc = 0;
    while (!o_val && cyc < 2000) begin @(negedge clk); cyc++; end
    if (!o_val) begin chk("val_timeout", 0, 1); return; end
    d0 = o_dat;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("val_hold", o_val, 1);
      chk("dat_hold", o_dat, d0);
      chk("rdy_hold", o_rdy, 0);
    end
    res = o_dat; ctl = o_ctl; err = o_err;
    i_rdy = 1'b1;
    @(negedge clk);
    i_rdy = 1'b0;
    chk("rdy_back", o_rdy, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] res;
    logic [CW-1:0] ctl;
    logic          err;
    int n0, cyc;
    int stall_ops [3] = '{2, 7, 11};

    repeat (3) @(negedge clk);
    chk("rst_rdy", o_rdy, 0);
    chk("rst_val", o_val, 0);
    chk("rst_mval", o_mul_val, 0);
    chk("rst_mrdy", o_mul_rdy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_dat", o_dat, 0);
    chk("rst_ctl", o_ctl, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", o_rdy, 1);

    n0 = req_cnt;
    run_op(5'd3, 16'h1234, 0, res, ctl, err);
    chk("a3_dat", res, 6);
    chk("a3_ctl", ctl, 16'h1234);
    chk("a3_err", err, 0);
    chk("a3_nreq", req_cnt - n0, 6);
    for (int k = 0; k < 6; k++) begin
      chk("a3_req_a", log_a[(n0 + k) & 255], exp_a[k]);
      chk("a3_req_b", log_b[(n0 + k) & 255], exp_b[k]);
    end

    run_op(5'd1, 16'h0001, 0, res, ctl, err);
    chk("a1_dat", res, 1);
    run_op(5'd16, 16'hbeef, 0, res, ctl, err);
    chk("a16_dat", res, 16);

    for (int a = 1; a < 17; a++) begin
      run_op(DW'(a), CW'(a * 16'h0101), 0, res, ctl, err);
      chk("sweep_dat", res, inv_tab[a]);
      chk("sweep_ctl", ctl, CW'(a * 16'h0101));
    end

    stall_en = 1'b1; rand_lat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_op(DW'(stall_ops[k]), CW'(16'ha000 + k), 20, res, ctl, err);
      chk("stall_dat", res, inv_tab[stall_ops[k]]);
      chk("stall_ctl", ctl, CW'(16'ha000 + k));
    end
    stall_en = 1'b0; rand_lat = 1'b0;

    // Abort a=5 while the first multiply product is outstanding.
    n0 = req_cnt;
    i_dat = 5'd5; i_ctl = 16'h5555; i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0; i_dat = '0; i_ctl = '0;
    cyc = 0;
    while (!(o_mul_rdy && (req_cnt - n0 == 2)) && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reach_mul_wait", {31'd0, o_mul_rdy} + 32'(req_cnt - n0), 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_rdy", o_rdy, 0);
    chk("mrst_val", o_val, 0);
    chk("mrst_mval", o_mul_val, 0);
    chk("mrst_mrdy", o_mul_rdy, 0);
    chk("mrst_dat", o_dat, 0);
    chk("mrst_ctl", o_ctl, 0);
    chk("mrst_ma", o_mul_dat_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_idle", o_rdy, 1);
    run_op(5'd5, 16'h0505, 0, res, ctl, err);
    chk("a5_dat", res, 7);
    chk("a5_ctl", ctl, 16'h0505);

    n0 = req_cnt;
    run_op(5'd0, 16'h0f0f, 0, res, ctl, err);
    chk("a0_dat", res, 0);
    chk("a0_ctl", ctl, 16'h0f0f);
`ifdef EC_FP_INV_ZERO_CHECK_EN
    chk("a0_err", err, 1);
    chk("a0_nreq", req_cnt - n0, 0);
`else
    chk("a0_err", err, 0);
    chk("a0_nreq", req_cnt - n0, 6);
`endif

    run_op(5'd9, 16'h0909, 0, res, ctl, err);
    chk("a9_dat", res, 2);
    chk("a9_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
